// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
// Turns the PS/2 byte stream into whole key events (make/break plus the
// E0 extended flag) and queues them in a small FIFO for the mode FSM.
// The decoder is throttled through ps2_in_en whenever the FIFO is full.
// Optional feature macro: KEY_REPEAT_FILTER_EN drops typematic repeats
// of the key that is currently held down.
module ps2_key_event_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_valid,
  input  logic             ps2_overflow,
  output logic             ps2_in_en,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow_err,
  output logic             proto_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0
  } prefix_state_t;

  prefix_state_t state, state_next;

  logic          is_e0;
  logic          is_f0;
  logic          is_discard;
  logic          byte_take;

  logic          dec_push;
  logic          dec_ext;
  logic          dec_brk;
  logic          proto_set;

  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          fifo_full;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [9:0]    head;

  // Classify the incoming byte; status bytes from the keyboard never
  // advance the prefix machine, and an overflow cycle ignores the byte.
  always_comb begin
    is_e0      = (ps2_data == 8'hE0);
    is_f0      = (ps2_data == 8'hF0);
    is_discard = (ps2_data == 8'h00) || (ps2_data == 8'hAA) ||
                 (ps2_data == 8'hFA) || (ps2_data == 8'hFE) ||
                 (ps2_data == 8'hFF);
    byte_take  = ps2_valid && !ps2_overflow && !is_discard;
  end

  // Prefix state register.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Prefix next-state logic; a decoder overflow abandons any partial sequence.
  always_comb begin
    state_next = state;
    if (ps2_overflow) begin
      state_next = ST_IDLE;
    end else if (byte_take) begin
      case (state)
        ST_IDLE: begin
          if (is_e0)      state_next = ST_E0;
          else if (is_f0) state_next = ST_F0;
          else            state_next = ST_IDLE;
        end
        ST_E0: begin
          if (is_f0)      state_next = ST_E0F0;
          else if (is_e0) state_next = ST_E0;
          else            state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Prefix outputs: which event (if any) the current byte completes, and
  // whether it forms an illegal prefix sequence.
  always_comb begin
    dec_push  = 1'b0;
    dec_ext   = 1'b0;
    dec_brk   = 1'b0;
    proto_set = 1'b0;
    if (byte_take) begin
      case (state)
        ST_IDLE: begin
          dec_push = !is_e0 && !is_f0;
        end
        ST_E0: begin
          if (is_e0) begin
            proto_set = 1'b1;
          end else if (!is_f0) begin
            dec_push = 1'b1;
            dec_ext  = 1'b1;
          end
        end
        ST_F0: begin
          if (is_e0 || is_f0) begin
            proto_set = 1'b1;
          end else begin
            dec_push = 1'b1;
            dec_brk  = 1'b1;
          end
        end
        default: begin
          if (is_e0 || is_f0) begin
            proto_set = 1'b1;
          end else begin
            dec_push = 1'b1;
            dec_ext  = 1'b1;
            dec_brk  = 1'b1;
          end
        end
      endcase
    end
  end

`ifdef KEY_REPEAT_FILTER_EN
  logic       held_valid;
  logic [7:0] held_code;
  logic       held_ext;
  logic       held_match;

  // A make of the key already held down is a typematic repeat and is dropped.
  always_comb begin
    held_match = held_valid && (held_code == ps2_data) && (held_ext == dec_ext);
    push_req   = dec_push && !(held_match && !dec_brk);
  end

  // Track the held key only for events that actually entered the FIFO.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      held_valid <= 1'b0;
      held_code  <= 8'h00;
      held_ext   <= 1'b0;
    end else if (push_ok) begin
      if (!dec_brk) begin
        held_valid <= 1'b1;
        held_code  <= ps2_data;
        held_ext   <= dec_ext;
      end else if (held_match) begin
        held_valid <= 1'b0;
      end
    end
  end
`else
  // Without the filter every decoded event is offered to the FIFO.
  always_comb begin
    push_req = dec_push;
  end
`endif

  // FIFO handshake decisions, all based on the level at the start of the cycle.
  always_comb begin
    fifo_full = (fifo_level == LVL_W'(FIFO_DEPTH));
    push_ok   = push_req && !fifo_full;
    pop       = evt_valid && evt_ready;
    ps2_in_en = !fifo_full;
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // FIFO storage; entries are {break, ext, code}.
  always_ff @(posedge sys_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {dec_brk, dec_ext, ps2_data};
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      overflow_err <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      if (ps2_overflow || (push_req && fifo_full)) overflow_err <= 1'b1;
      if (proto_set)                                proto_err    <= 1'b1;
    end
  end

  // Head presentation; fields read as zero while the FIFO is empty.
  always_comb begin
    head      = mem[rd_ptr];
    evt_valid = (fifo_level != '0);
    evt_code  = evt_valid ? head[7:0] : 8'h00;
    evt_ext   = evt_valid ? head[8]   : 1'b0;
    evt_break = evt_valid ? head[9]   : 1'b0;
  end

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb_ps2_key_event_ctrl
// Directed bench for ps2_key_event_ctrl with an event scoreboard.
// Honours KEY_REPEAT_FILTER_EN when deciding how many repeats survive.
module tb_ps2_key_event_ctrl;

  logic       sys_clk;
  logic       rst;
  logic [7:0] ps2_data;
  logic       ps2_valid;
  logic       ps2_overflow;
  logic       ps2_in_en;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [2:0] fifo_level;
  logic       overflow_err;
  logic       proto_err;

  int checks   = 0;
  int failures = 0;

  // Expected events, {break, ext, code}, in the order they must leave the FIFO.
  logic [9:0] sb [$];

  ps2_key_event_ctrl #(
    .FIFO_DEPTH (4),
    .LVL_W      (3)
  ) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .ps2_data     (ps2_data),
    .ps2_valid    (ps2_valid),
    .ps2_overflow (ps2_overflow),
    .ps2_in_en    (ps2_in_en),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_ext      (evt_ext),
    .evt_break    (evt_break),
    .fifo_level   (fifo_level),
    .overflow_err (overflow_err),
    .proto_err    (proto_err)
  );

  // Free-running clock.
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one byte to the DUT for a single clock; returns at the next negedge.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge sys_clk);
    ps2_data  = b;
    ps2_valid = 1'b1;
    @(negedge sys_clk);
    ps2_valid = 1'b0;
    ps2_data  = 8'h00;
  endtask

  // Hold reset for the given number of cycles and forget pending expectations.
  task automatic applyReset(input int cycles);
    @(negedge sys_clk);
    rst = 1'b1;
    repeat (cycles) @(negedge sys_clk);
    rst = 1'b0;
    sb.delete();
  endtask

  // Check the idle/reset-like flag state.
  task automatic checkClean(input string tag);
    checkOutput({tag, "_valid"},  evt_valid,    0);
    checkOutput({tag, "_code"},   evt_code,     0);
    checkOutput({tag, "_ext"},    evt_ext,      0);
    checkOutput({tag, "_break"},  evt_break,    0);
    checkOutput({tag, "_level"},  fifo_level,   0);
    checkOutput({tag, "_in_en"},  ps2_in_en,    1);
    checkOutput({tag, "_ovf"},    overflow_err, 0);
    checkOutput({tag, "_proto"},  proto_err,    0);
  endtask

  // Pop every scoreboard entry off the DUT, comparing the head each time.
  task automatic drainAll(input string tag);
    logic [9:0] e;
    int         n;
    n = 0;
    checkOutput({tag, "_count"}, fifo_level, sb.size());
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput($sformatf("%s_v%0d", tag, n),   evt_valid, 1);
      checkOutput($sformatf("%s_c%0d", tag, n),   evt_code,  e[7:0]);
      checkOutput($sformatf("%s_e%0d", tag, n),   evt_ext,   e[8]);
      checkOutput($sformatf("%s_b%0d", tag, n),   evt_break, e[9]);
      evt_ready = 1'b1;
      @(negedge sys_clk);
      evt_ready = 1'b0;
      n++;
    end
    checkOutput({tag, "_empty_valid"}, evt_valid,  0);
    checkOutput({tag, "_empty_level"}, fifo_level, 0);
    checkOutput({tag, "_empty_code"},  evt_code,   0);
  endtask

  initial begin
    rst          = 1'b1;
    ps2_data     = 8'h00;
    ps2_valid    = 1'b0;
    ps2_overflow = 1'b0;
    evt_ready    = 1'b0;

    // Reset state.
    applyReset(2);
    checkClean("reset");

    // Single make with one-cycle latency and stable head while not accepted.
    applyStimulus(8'h1C);
    sb.push_back({1'b0, 1'b0, 8'h1C});
    checkOutput("lat_valid", evt_valid, 1);
    checkOutput("lat_code",  evt_code,  8'h1C);
    repeat (2) @(negedge sys_clk);
    checkOutput("hold_code", evt_code,  8'h1C);
    checkOutput("hold_lvl",  fifo_level, 1);
    drainAll("make1c");

    // Extended make, then extended break pushed while the make is popped.
    applyStimulus(8'hE0);
    applyStimulus(8'h75);
    sb.push_back({1'b0, 1'b1, 8'h75});
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    checkOutput("ext_lvl_pre", fifo_level, 1);
    @(negedge sys_clk);
    checkOutput("ext_make_c", evt_code,  8'h75);
    checkOutput("ext_make_e", evt_ext,   1);
    checkOutput("ext_make_b", evt_break, 0);
    void'(sb.pop_front());
    ps2_data  = 8'h75;
    ps2_valid = 1'b1;
    evt_ready = 1'b1;
    sb.push_back({1'b1, 1'b1, 8'h75});
    @(negedge sys_clk);
    ps2_valid = 1'b0;
    evt_ready = 1'b0;
    checkOutput("pushpop_lvl", fifo_level, 1);
    drainAll("ext_brk");
    checkOutput("ext_ovf",   overflow_err, 0);
    checkOutput("ext_proto", proto_err,    0);

    // Typematic repeats of a held key.
    applyStimulus(8'h1C);
    applyStimulus(8'h1C);
    applyStimulus(8'h1C);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    sb.push_back({1'b0, 1'b0, 8'h1C});
`ifndef KEY_REPEAT_FILTER_EN
    sb.push_back({1'b0, 1'b0, 8'h1C});
    sb.push_back({1'b0, 1'b0, 8'h1C});
`endif
    sb.push_back({1'b1, 1'b0, 8'h1C});
    drainAll("repeat");

    // Status bytes are ignored, even in the middle of a prefix.
    applyStimulus(8'hE0);
    applyStimulus(8'hFA);
    applyStimulus(8'hAA);
    applyStimulus(8'h6B);
    sb.push_back({1'b0, 1'b1, 8'h6B});
    drainAll("discard");

    // Fill the FIFO, then overrun it.
    applyStimulus(8'h15);
    applyStimulus(8'h1D);
    applyStimulus(8'h24);
    checkOutput("fill3_in_en", ps2_in_en, 1);
    applyStimulus(8'h2D);
    checkOutput("fill4_lvl",   fifo_level, 4);
    checkOutput("fill4_in_en", ps2_in_en,  0);
    checkOutput("fill4_ovf",   overflow_err, 0);
    applyStimulus(8'h2C);
    checkOutput("over_lvl", fifo_level,   4);
    checkOutput("over_ovf", overflow_err, 1);
    sb.push_back({1'b0, 1'b0, 8'h15});
    sb.push_back({1'b0, 1'b0, 8'h1D});
    sb.push_back({1'b0, 1'b0, 8'h24});
    sb.push_back({1'b0, 1'b0, 8'h2D});
    drainAll("fifo");
    checkOutput("fifo_in_en", ps2_in_en,    1);
    checkOutput("fifo_ovf",   overflow_err, 1);

    // Illegal double break prefix.
    applyReset(1);
    applyStimulus(8'hF0);
    applyStimulus(8'hF0);
    checkOutput("proto_flag", proto_err,  1);
    checkOutput("proto_lvl",  fifo_level, 0);
    applyStimulus(8'h1C);
    sb.push_back({1'b0, 1'b0, 8'h1C});
    drainAll("proto");

    // Reset in the middle of an extended sequence.
    applyStimulus(8'hE0);
    applyReset(1);
    checkClean("midreset");
    applyStimulus(8'h75);
    sb.push_back({1'b0, 1'b0, 8'h75});
    drainAll("midreset_evt");

    // Decoder overflow swallows its byte and abandons the prefix.
    applyStimulus(8'hE0);
    @(negedge sys_clk);
    ps2_overflow = 1'b1;
    ps2_valid    = 1'b1;
    ps2_data     = 8'h75;
    @(negedge sys_clk);
    ps2_overflow = 1'b0;
    ps2_valid    = 1'b0;
    checkOutput("dovf_flag", overflow_err, 1);
    checkOutput("dovf_lvl",  fifo_level,   0);
    applyStimulus(8'h74);
    sb.push_back({1'b0, 1'b0, 8'h74});
    drainAll("dovf_evt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_ctrl.md
# ps2_key_event_ctrl

Sequences the raw byte stream from `PS2Decoder` into whole key events (make/break, extended flag) and buffers them for the mode FSM in the top level. It drives the decoder's `in_en` as backpressure and filters typematic repeats of a held key. The mode FSM consumes one event per `evt_valid && evt_ready` handshake instead of pattern-matching bytes and prefixes itself.

## Interface
- `FIFO_DEPTH`, default 4: event buffer depth. Must be a power of 2 and at least 2.
- `LVL_W`, default 3: width of `fifo_level`, equal to log2(`FIFO_DEPTH`) + 1.
- `sys_clk`, in, 1: system clock. The block uses this single clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `ps2_data`, in, 8: byte from `PS2Decoder.data`.
- `ps2_valid`, in, 1: `PS2Decoder.out_en`, a one-cycle pulse per received byte.
- `ps2_overflow`, in, 1: `PS2Decoder.overflow`.
- `ps2_in_en`, out, 1: drives `PS2Decoder.in_en`. Equals `fifo_level != FIFO_DEPTH`.
- `evt_valid`, out, 1: the FIFO head is valid.
- `evt_ready`, in, 1: consumer accepts the head.
- `evt_code`, out, 8: scan code of the head event.
- `evt_ext`, out, 1: the event was E0-prefixed.
- `evt_break`, out, 1: 1 for a release, 0 for a press.
- `fifo_level`, out, `LVL_W`: number of buffered events.
- `overflow_err`, out, 1: sticky flag, set by a dropped byte or by `ps2_overflow`.
- `proto_err`, out, 1: sticky flag, set by an illegal prefix sequence.

## Operation
- The prefix FSM has four states: IDLE, E0, F0, E0F0. Bytes are consumed only on `ps2_valid`.
- In IDLE:
  - 0xE0 goes to E0. 0xF0 goes to F0.
  - Any other byte pushes a make event {code, ext=0}.
- In E0:
  - 0xF0 goes to E0F0.
  - 0xE0 sets `proto_err` and stays in E0.
  - Any other byte pushes a make event {code, ext=1} and returns to IDLE.
- In F0, any byte other than a prefix pushes a break event {code, ext=0} and returns to IDLE.
- In E0F0, any byte other than a prefix pushes a break event {code, ext=1} and returns to IDLE.
- In F0 or E0F0, receiving 0xE0 or 0xF0 sets `proto_err`, discards the sequence and returns to IDLE.
- Bytes 0x00, 0xAA, 0xFA, 0xFE and 0xFF are discarded in every state. The state does not change.
- `ps2_overflow` high sets `overflow_err` and forces IDLE. A byte with `ps2_valid` in the same cycle is ignored.
- Repeat filter (only when `KEY_REPEAT_FILTER_EN` is defined):
  - Registers `held_valid`, `held_code` and `held_ext` track the last pressed key.
  - A make matching the held key while `held_valid` is set is dropped and not pushed.
  - Any other make is pushed and becomes the held key.
  - A break always pushes. If it matches the held key, it clears `held_valid`.
  - Held state updates only when the event is actually pushed, or dropped as a repeat.
- FIFO:
  - A push is accepted when `fifo_level < FIFO_DEPTH` at the start of the cycle.
  - A push while full is dropped and sets `overflow_err`, even if a pop occurs in the same cycle.
  - A pop occurs on `evt_valid && evt_ready`.
  - Simultaneous push and pop when not full leaves `fifo_level` unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- `evt_code`, `evt_ext` and `evt_break` show the head entry while `evt_valid` is 1, and are 0 otherwise.
- Error flags clear only on `rst`.

## Timing
- Reset values:
  - State = IDLE, pointers = 0, `held_valid` = 0.
  - `evt_valid` = 0, `evt_code` = 0, `evt_ext` = 0, `evt_break` = 0.
  - `fifo_level` = 0, `overflow_err` = 0, `proto_err` = 0.
  - `ps2_in_en` = 1 in the first cycle after reset, since the FIFO is empty.
- Reset mid-sequence, for example after E0, discards the prefix. The next byte is decoded from IDLE.
- Latency: the final byte of a sequence with `ps2_valid` in cycle N gives `evt_valid` = 1 in cycle N+1, if the FIFO was empty.
- The FIFO is registered. There is no combinational path from `ps2_data` to `evt_*`.
- `evt_*` must remain stable while `evt_valid && !evt_ready`.
- `ps2_in_en` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the pop that makes room.
- Throughput: one event pushed and one popped per cycle, at most.

## Configuration
- `KEY_REPEAT_FILTER_EN` defined: the repeat filter above is compiled in.
- Not defined: the held registers are absent, and every make is pushed, so typematic repeats reach the consumer.

## Test plan
- Byte 0x1C -> one event {code 0x1C, ext 0, break 0}, with `evt_valid` one cycle after `ps2_valid`.
- Bytes E0 75, then E0 F0 75 -> {0x75, ext 1, break 0}, then {0x75, ext 1, break 1}. Errors stay 0.
- With `KEY_REPEAT_FILTER_EN`: 1C 1C 1C F0 1C -> exactly two events, make 0x1C and break 0x1C. Without the macro -> four events.
- With `FIFO_DEPTH` = 4 and `evt_ready` = 0: makes 15, 1D, 24, 2D, 2C -> `fifo_level` = 4, `ps2_in_en` = 0 after the 4th, 0x2C dropped, `overflow_err` = 1. Then popping with `evt_ready` = 1 returns 15, 1D, 24, 2D in order.
- Bytes F0 F0 1C -> `proto_err` = 1 and no break is emitted. Then 1C -> make 0x1C.
- E0, then `rst` for 1 cycle, then 75 -> make {0x75, ext 0}. All flags are 0 after reset.
